// File: rtl/gf180mcu_osu_sc_gp9t3v3__xoracc.sv
// Registered XOR/XNOR datapath with frame-based XOR folding and a one-entry
// valid/ready output register. P is the parity of the registered result.
module gf180mcu_osu_sc_gp9t3v3__xoracc #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             R,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       MODE,
    input  logic             IN_VALID,
    input  logic             IN_LAST,
    output logic             IN_READY,
    output logic [WIDTH-1:0] Y,
    output logic             P,
    output logic [CNT_W-1:0] CNT,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    typedef enum logic {IDLE, FOLD} state_t;

    state_t             state_q, state_d;
    logic               run_q, run_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   beats_q, beats_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ov_q, ov_d;

    logic               accept;
    logic [WIDTH-1:0]   term;
    logic [WIDTH-1:0]   sum;
    logic [CNT_W-1:0]   beats_inc;

    always_comb begin
        IN_READY  = !ov_q || OUT_READY;
        accept    = IN_VALID && IN_READY;
        term      = A ^ B;
        sum       = acc_q ^ term;
        beats_inc = (beats_q == {CNT_W{1'b1}}) ? beats_q : beats_q + CNT_W'(1);

        state_d = state_q;
        run_d   = run_q;
        acc_d   = acc_q;
        beats_d = beats_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        // A drained entry empties unless something is emitted below.
        ov_d    = ov_q && !OUT_READY;

        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (!MODE[1]) begin
                        y_d   = MODE[0] ? ~term : term;
                        cnt_d = CNT_W'(1);
                        ov_d  = 1'b1;
                    end else if (IN_LAST) begin
                        // Single-beat frame: emit and leave accumulator clear.
                        y_d     = term;
                        cnt_d   = CNT_W'(1);
                        ov_d    = 1'b1;
                        acc_d   = '0;
                        beats_d = '0;
                    end else begin
                        acc_d   = term;
                        beats_d = CNT_W'(1);
                        run_d   = MODE[0];
                        state_d = FOLD;
                        if (MODE[0]) begin
                            y_d   = term;
                            cnt_d = CNT_W'(1);
                            ov_d  = 1'b1;
                        end
                    end
                end
                FOLD: begin
                    if (run_q || IN_LAST) begin
                        y_d   = sum;
                        cnt_d = beats_inc;
                        ov_d  = 1'b1;
                    end
                    if (IN_LAST) begin
                        acc_d   = '0;
                        beats_d = '0;
                        state_d = IDLE;
                    end else begin
                        acc_d   = sum;
                        beats_d = beats_inc;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
            acc_q   <= '0;
            beats_q <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            acc_q   <= acc_d;
            beats_q <= beats_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
        end
    end

    assign Y         = y_q;
    assign P         = ^y_q;
    assign CNT       = cnt_q;
    assign OUT_VALID = ov_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__xoracc.sv
// Directed bench for the XOR accumulator: two instances (CNT_W=4 and CNT_W=2)
// share stimulus; the narrow one exercises beat-counter saturation.
module tb_gf180mcu_osu_sc_gp9t3v3__xoracc;

    logic       CLK = 1'b0;
    logic       R;
    logic [7:0] A, B;
    logic [1:0] MODE;
    logic       IN_VALID, IN_LAST, OUT_READY;

    logic       in_ready, p, ov;
    logic [7:0] y;
    logic [3:0] cnt;
    logic       in_ready2, p2, ov2;
    logic [7:0] y2;
    logic [1:0] cnt2;

    int nchk = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    gf180mcu_osu_sc_gp9t3v3__xoracc #(.WIDTH(8), .CNT_W(4)) dut (
        .CLK(CLK), .R(R), .A(A), .B(B), .MODE(MODE), .IN_VALID(IN_VALID),
        .IN_LAST(IN_LAST), .IN_READY(in_ready), .Y(y), .P(p), .CNT(cnt),
        .OUT_VALID(ov), .OUT_READY(OUT_READY)
    );

    gf180mcu_osu_sc_gp9t3v3__xoracc #(.WIDTH(8), .CNT_W(2)) dut2 (
        .CLK(CLK), .R(R), .A(A), .B(B), .MODE(MODE), .IN_VALID(IN_VALID),
        .IN_LAST(IN_LAST), .IN_READY(in_ready2), .Y(y2), .P(p2), .CNT(cnt2),
        .OUT_VALID(ov2), .OUT_READY(OUT_READY)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] ey, input logic ep,
                           input logic [3:0] ecnt, input logic eov);
        chk({tag, ".Y"},   32'(y),   32'(ey));
        chk({tag, ".P"},   32'(p),   32'(ep));
        chk({tag, ".CNT"}, 32'(cnt), 32'(ecnt));
        chk({tag, ".OV"},  32'(ov),  32'(eov));
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic beat(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                        input logic last);
        MODE = m; A = a; B = b; IN_VALID = 1'b1; IN_LAST = last;
    endtask

    task automatic idle_in;
        IN_VALID = 1'b0; IN_LAST = 1'b0;
    endtask

    initial begin
        R = 1'b1; A = '0; B = '0; MODE = 2'b00; IN_VALID = 1'b0; IN_LAST = 1'b0;
        OUT_READY = 1'b1;
        #12;
        chk_out("reset", 8'h00, 1'b0, 4'd0, 1'b0);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        @(negedge CLK);
        R = 1'b0;

        // Plain XOR
        beat(2'b00, 8'hA5, 8'h0F, 1'b0);
        tick();
        chk_out("xor", 8'hAA, 1'b0, 4'd1, 1'b1);

        // Async reset mid-stream clears outputs immediately
        beat(2'b00, 8'h12, 8'h34, 1'b0);
        OUT_READY = 1'b0;
        #2 R = 1'b1;
        #1;
        chk_out("rst_async", 8'h00, 1'b0, 4'd0, 1'b0);
        chk("rst_async.in_ready", 32'(in_ready), 32'd1);
        tick();
        chk_out("rst_hold", 8'h00, 1'b0, 4'd0, 1'b0);
        @(negedge CLK);
        R = 1'b0;
        OUT_READY = 1'b1;

        // XNOR: ~(FF^01) = 01
        beat(2'b01, 8'hFF, 8'h01, 1'b0);
        tick();
        chk_out("xnor", 8'h01, 1'b1, 4'd1, 1'b1);

        // Fold frame, mode change mid-frame ignored
        beat(2'b10, 8'h01, 8'h00, 1'b0);
        tick();
        chk("fold.b1.ov", 32'(ov), 32'd0);
        beat(2'b00, 8'h02, 8'h00, 1'b0);
        tick();
        chk("fold.b2.ov", 32'(ov), 32'd0);
        beat(2'b00, 8'h04, 8'h00, 1'b1);
        tick();
        chk_out("fold.last", 8'h07, 1'b1, 4'd3, 1'b1);

        // Running fold with backpressure
        beat(2'b11, 8'h0F, 8'h00, 1'b0);
        tick();
        chk_out("run.b1", 8'h0F, 1'b0, 4'd1, 1'b1);
        OUT_READY = 1'b0;
        beat(2'b11, 8'hF0, 8'h00, 1'b0);
        #1;
        chk("run.bp.in_ready", 32'(in_ready), 32'd0);
        tick();
        chk_out("run.hold", 8'h0F, 1'b0, 4'd1, 1'b1);
        OUT_READY = 1'b1;
        tick();
        chk_out("run.b2", 8'hFF, 1'b0, 4'd2, 1'b1);
        beat(2'b11, 8'hFF, 8'h00, 1'b1);
        tick();
        chk_out("run.b3", 8'h00, 1'b0, 4'd3, 1'b1);
        idle_in();
        tick();
        chk("run.drain.ov", 32'(ov), 32'd0);
        // New frame starts from a cleared accumulator
        beat(2'b11, 8'h11, 8'h00, 1'b0);
        tick();
        chk_out("run2.b1", 8'h11, 1'b0, 4'd1, 1'b1);
        beat(2'b11, 8'h00, 8'h00, 1'b1);
        tick();
        chk_out("run2.b2", 8'h11, 1'b0, 4'd2, 1'b1);

        // Saturation: 5 beats of 01 -> Y=01; CNT 5 (4-bit), 3 (2-bit)
        for (int i = 0; i < 5; i++) begin
            beat(2'b10, 8'h01, 8'h00, i == 4);
            tick();
        end
        chk_out("sat.w4", 8'h01, 1'b1, 4'd5, 1'b1);
        chk("sat.w2.Y",   32'(y2),   32'h01);
        chk("sat.w2.CNT", 32'(cnt2), 32'd3);
        chk("sat.w2.OV",  32'(ov2),  32'd1);
        idle_in();
        tick();

        // Reset mid-frame discards the open frame
        beat(2'b10, 8'h55, 8'h00, 1'b0);
        tick();
        beat(2'b10, 8'h33, 8'h00, 1'b0);
        tick();
        chk("midrst.ov", 32'(ov), 32'd0);
        idle_in();
        R = 1'b1;
        #1;
        chk_out("midrst.rst", 8'h00, 1'b0, 4'd0, 1'b0);
        @(negedge CLK);
        R = 1'b0;
        beat(2'b00, 8'h3C, 8'h00, 1'b0);
        tick();
        chk_out("midrst.xor", 8'h3C, 1'b0, 4'd1, 1'b1);
        idle_in();
        tick();
        chk("midrst.drain", 32'(ov), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
